// File: rtl/layer_controller_if.sv
// Bundle of handshakes between a layer controller, its upstream and downstream
// neighbours, and its M node instances.
interface layer_controller_if #(
  parameter int N = 2,
  parameter int M = 2
);
  logic             train;
  logic             argument_valid;
  logic [N*8-1:0]   argument_data;
  logic             argument_ready;
  logic             result_valid;
  logic [M*16-1:0]  result_data;
  logic             result_ready;
  logic             error_valid;
  logic [M*16-1:0]  error_data;
  logic             error_ready;
  logic             propagate_valid;
  logic [N*16-1:0]  propagate_data;
  logic             propagate_ready;
  logic [M-1:0]     node_train;
  logic [M-1:0]     node_argument_valid;
  logic [N*8-1:0]   node_argument_data;
  logic [M-1:0]     node_argument_ready;
  logic [M-1:0]     node_result_valid;
  logic [M*16-1:0]  node_result_data;
  logic [M-1:0]     node_result_ready;
  logic [M-1:0]     node_error_valid;
  logic [M*16-1:0]  node_error_data;
  logic [M-1:0]     node_error_ready;
  logic [M-1:0]     node_propagate_valid;
  logic [M*N*16-1:0] node_propagate_data;
  logic [M-1:0]     node_propagate_ready;

  // Controller side
  modport slave (
    input  train, argument_valid, argument_data, result_ready,
           error_valid, error_data, propagate_ready,
           node_argument_ready, node_result_valid, node_result_data,
           node_error_ready, node_propagate_valid, node_propagate_data,
    output argument_ready, result_valid, result_data, error_ready,
           propagate_valid, propagate_data, node_train,
           node_argument_valid, node_argument_data, node_result_ready,
           node_error_valid, node_error_data, node_propagate_ready
  );

  // Neighbouring layers and nodes
  modport master (
    output train, argument_valid, argument_data, result_ready,
           error_valid, error_data, propagate_ready,
           node_argument_ready, node_result_valid, node_result_data,
           node_error_ready, node_propagate_valid, node_propagate_data,
    input  argument_ready, result_valid, result_data, error_ready,
           propagate_valid, propagate_data, node_train,
           node_argument_valid, node_argument_data, node_result_ready,
           node_error_valid, node_error_data, node_propagate_ready
  );
endinterface

// File: rtl/layer_controller.sv
// Sequences one fully connected layer of M nodes: broadcast argument, gather
// results, and in training scatter errors and sum back-propagated vectors.
module layer_controller #(
  parameter int N = 2,
  parameter int M = 2
) (
  input logic          clock,
  input logic          reset,
  layer_controller_if.slave bus
);
  // Wide enough to sum M signed 16-bit values without overflow
  localparam int ACCW = 16 + $clog2(M) + 1;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32'sd32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32'sd32768);

  typedef enum logic [2:0] {ARG, BCST, GATH, RES, ERR, SCAT, COLL, PROP} state_t;

  state_t                  state_r;
  logic [M-1:0]            done_r;
  logic [M-1:0]            hs_s;
  logic                    all_done_s;
  logic                    train_r;
  logic [N*8-1:0]          arg_r;
  logic [M*16-1:0]         res_r;
  logic [M*16-1:0]         err_r;
  logic signed [ACCW-1:0]  acc_r [N];
  logic signed [ACCW-1:0]  acc_next_s [N];

  function automatic logic signed [ACCW-1:0] sext16(input logic [15:0] v);
    return {{(ACCW-16){v[15]}}, v};
  endfunction

  function automatic logic [15:0] sat16(input logic signed [ACCW-1:0] v);
    if (v > SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < SAT_MIN) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Per-node handshakes completing this cycle in the active scatter/gather phase
  always_comb begin
    hs_s = '0;
    case (state_r)
      BCST:    hs_s = ~done_r & bus.node_argument_ready;
      GATH:    hs_s = ~done_r & bus.node_result_valid;
      SCAT:    hs_s = ~done_r & bus.node_error_ready;
      COLL:    hs_s = ~done_r & bus.node_propagate_valid;
      default: hs_s = '0;
    endcase
  end

  assign all_done_s = &(done_r | hs_s);

  // Accumulator update: every node handshaking this cycle is added in
  always_comb begin
    for (int n = 0; n < N; n++) begin
      acc_next_s[n] = acc_r[n];
      for (int m = 0; m < M; m++) begin
        acc_next_s[n] = acc_next_s[n] +
          (hs_s[m] ? sext16(bus.node_propagate_data[16*(m*N+n) +: 16]) : {ACCW{1'b0}});
      end
    end
  end

  // Phase sequencing, done mask and all registered vectors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ARG;
      done_r  <= '0;
      train_r <= 1'b0;
      arg_r   <= '0;
      res_r   <= '0;
      err_r   <= '0;
      for (int n = 0; n < N; n++) acc_r[n] <= '0;
    end else begin
      case (state_r)
        ARG: begin
          if (bus.argument_valid) begin
            arg_r   <= bus.argument_data;
            train_r <= bus.train;
            done_r  <= '0;
            state_r <= BCST;
          end
        end
        BCST: begin
          if (all_done_s) begin
            done_r  <= '0;
            state_r <= GATH;
          end else begin
            done_r  <= done_r | hs_s;
          end
        end
        GATH: begin
          for (int m = 0; m < M; m++) begin
            if (hs_s[m]) res_r[16*m +: 16] <= bus.node_result_data[16*m +: 16];
          end
          if (all_done_s) begin
            done_r  <= '0;
            state_r <= RES;
          end else begin
            done_r  <= done_r | hs_s;
          end
        end
        RES: begin
          if (bus.result_ready) state_r <= train_r ? ERR : ARG;
        end
        ERR: begin
          if (bus.error_valid) begin
            err_r   <= bus.error_data;
            done_r  <= '0;
            state_r <= SCAT;
          end
        end
        SCAT: begin
          if (all_done_s) begin
            done_r  <= '0;
            for (int n = 0; n < N; n++) acc_r[n] <= '0;
            state_r <= COLL;
          end else begin
            done_r  <= done_r | hs_s;
          end
        end
        COLL: begin
          for (int n = 0; n < N; n++) acc_r[n] <= acc_next_s[n];
          if (all_done_s) begin
            done_r  <= '0;
            state_r <= PROP;
          end else begin
            done_r  <= done_r | hs_s;
          end
        end
        PROP: begin
          if (bus.propagate_ready) state_r <= ARG;
        end
        default: begin
          done_r  <= '0;
          state_r <= ARG;
        end
      endcase
    end
  end

  assign bus.argument_ready       = (state_r == ARG);
  assign bus.result_valid         = (state_r == RES);
  assign bus.error_ready          = (state_r == ERR);
  assign bus.propagate_valid      = (state_r == PROP);
  assign bus.node_argument_valid  = (state_r == BCST) ? ~done_r : {M{1'b0}};
  assign bus.node_result_ready    = (state_r == GATH) ? ~done_r : {M{1'b0}};
  assign bus.node_error_valid     = (state_r == SCAT) ? ~done_r : {M{1'b0}};
  assign bus.node_propagate_ready = (state_r == COLL) ? ~done_r : {M{1'b0}};
  assign bus.node_train           = {M{train_r}};
  assign bus.node_argument_data   = arg_r;
  assign bus.node_error_data      = err_r;
  assign bus.result_data          = res_r;

  for (genvar n = 0; n < N; n++) begin : g_prop
    assign bus.propagate_data[16*n +: 16] = sat16(acc_r[n]);
  end
endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller (N=2, M=2): directed table, random
// vectors against a sum-and-clamp reference, and a reset-during-collect sequence.
module tb_layer_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clock = ~clock;

  layer_controller_if #(.N(2), .M(2)) bus ();
  layer_controller #(.N(2), .M(2)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [15:0] arg;
    bit          train;
    logic [31:0] res;
    logic [31:0] err;
    logic [63:0] prop;
    logic [31:0] exp_prop;
    int ad0, ad1, rd0, rd1, ed0, ed1, pd0, pd1, bp;
  } vec_t;

  function automatic vec_t mk(logic [15:0] arg, bit train, logic [31:0] res,
                              logic [31:0] err, logic [63:0] prop, logic [31:0] exp_prop,
                              int ad0, int ad1, int rd0, int rd1, int ed0, int ed1,
                              int pd0, int pd1, int bp);
    vec_t v;
    v.arg = arg; v.train = train; v.res = res; v.err = err; v.prop = prop;
    v.exp_prop = exp_prop; v.ad0 = ad0; v.ad1 = ad1; v.rd0 = rd0; v.rd1 = rd1;
    v.ed0 = ed0; v.ed1 = ed1; v.pd0 = pd0; v.pd1 = pd1; v.bp = bp;
    return v;
  endfunction

  // Reference: element n = clamp(sum over nodes of signed element n)
  function automatic logic [31:0] model_prop(logic [63:0] p);
    logic [31:0] r;
    int s;
    logic [31:0] sv;
    for (int n = 0; n < 2; n++) begin
      s = 0;
      for (int m = 0; m < 2; m++) s += int'($signed(p[16*(m*2+n) +: 16]));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      sv = s;
      r[16*n +: 16] = sv[15:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_argument_ready"}, 64'(bus.argument_ready), 64'd1);
    chk({name, "_other_handshakes"},
        64'({bus.result_valid, bus.error_ready, bus.propagate_valid,
             bus.node_argument_valid, bus.node_result_ready,
             bus.node_error_valid, bus.node_propagate_ready}), 64'd0);
  endtask

  // One per-node phase; kind 0 arg, 1 result, 2 error, 3 propagate
  task automatic node_phase(input int kind, input int d0, input int d1);
    logic [1:0] seen, offer, dv, want;
    int c;
    seen = 2'b00;
    c = 0;
    while (seen != 2'b11 && c < 40) begin
      @(negedge clock);
      case (kind)
        0:       dv = bus.node_argument_valid;
        1:       dv = bus.node_result_ready;
        2:       dv = bus.node_error_valid;
        default: dv = bus.node_propagate_ready;
      endcase
      want = ~seen;
      chk($sformatf("phase%0d_node_mask", kind), 64'(dv), 64'(want));
      offer[0] = (c >= d0) && !seen[0];
      offer[1] = (c >= d1) && !seen[1];
      case (kind)
        0:       bus.node_argument_ready  = offer;
        1:       bus.node_result_valid    = offer;
        2:       bus.node_error_ready     = offer;
        default: bus.node_propagate_valid = offer;
      endcase
      seen = seen | (dv & offer);
      c++;
    end
    if (seen != 2'b11) chk($sformatf("phase%0d_timeout", kind), 64'(seen), 64'd3);
    @(posedge clock);
    #1;
    bus.node_argument_ready  = 2'b00;
    bus.node_result_valid    = 2'b00;
    bus.node_error_ready     = 2'b00;
    bus.node_propagate_valid = 2'b00;
  endtask

  task automatic do_arg(input logic [15:0] arg, input bit train);
    @(negedge clock);
    chk("argument_ready", 64'(bus.argument_ready), 64'd1);
    bus.argument_valid = 1'b1;
    bus.argument_data  = arg;
    bus.train          = train;
    @(posedge clock);
    #1;
    bus.argument_valid = 1'b0;
    bus.train          = 1'b0;
  endtask

  task automatic do_result(input logic [31:0] exp, input int bp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.result_valid) break;
    end
    chk("result_valid", 64'(bus.result_valid), 64'd1);
    chk("result_data", 64'(bus.result_data), 64'(exp));
    chk("error_ready_in_res", 64'(bus.error_ready), 64'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk("result_valid_held", 64'(bus.result_valid), 64'd1);
      chk("result_data_held", 64'(bus.result_data), 64'(exp));
    end
    bus.result_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.result_ready = 1'b0;
  endtask

  task automatic do_error(input logic [31:0] err);
    @(negedge clock);
    chk("error_ready", 64'(bus.error_ready), 64'd1);
    chk("result_valid_dropped", 64'(bus.result_valid), 64'd0);
    bus.error_valid = 1'b1;
    bus.error_data  = err;
    @(posedge clock);
    #1;
    bus.error_valid = 1'b0;
  endtask

  task automatic do_prop(input logic [31:0] exp, input int bp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.propagate_valid) break;
    end
    chk("propagate_valid", 64'(bus.propagate_valid), 64'd1);
    chk("propagate_data", 64'(bus.propagate_data), 64'(exp));
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk("propagate_valid_held", 64'(bus.propagate_valid), 64'd1);
      chk("propagate_data_held", 64'(bus.propagate_data), 64'(exp));
    end
    bus.propagate_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.propagate_ready = 1'b0;
    @(negedge clock);
    chk("back_to_arg", 64'(bus.argument_ready), 64'd1);
    chk("propagate_valid_dropped", 64'(bus.propagate_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bus.node_result_data    = v.res;
    bus.node_propagate_data = v.prop;
    do_arg(v.arg, v.train);
    node_phase(0, v.ad0, v.ad1);
    chk("node_argument_data", 64'(bus.node_argument_data), 64'(v.arg));
    chk("node_train", 64'(bus.node_train), 64'({v.train, v.train}));
    node_phase(1, v.rd0, v.rd1);
    do_result(v.res, v.bp);
    if (v.train) begin
      do_error(v.err);
      node_phase(2, v.ed0, v.ed1);
      chk("node_error_data", 64'(bus.node_error_data), 64'(v.err));
      node_phase(3, v.pd0, v.pd1);
      do_prop(v.exp_prop, v.bp);
    end else begin
      @(negedge clock);
      chk("no_train_back_to_arg", 64'(bus.argument_ready), 64'd1);
      chk("no_train_error_ready", 64'(bus.error_ready), 64'd0);
    end
  endtask

  initial begin
    vec_t tbl [6];
    vec_t rv;
    logic [63:0] rp;

    tbl[0] = mk(16'h2040, 1'b0, 32'hFF00_0123, 32'h0, 64'h0, 32'h0,
                0, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[1] = mk(16'h0705, 1'b0, 32'h1111_2222, 32'h0, 64'h0, 32'h0,
                1, 4, 2, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(16'h3344, 1'b1, 32'h0042_0024, 32'hFFF0_0010,
                64'h0002_0007_FFFD_0005, 32'hFFFF_000C, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(16'h0101, 1'b1, 32'h0001_0002, 32'h0001_0002,
                64'h0000_7000_0000_7000, 32'h0000_7FFF, 0, 1, 1, 0, 2, 0, 0, 2, 0);
    tbl[4] = mk(16'h0202, 1'b1, 32'h0003_0004, 32'h0005_0006,
                64'h0000_9000_0000_9000, 32'h0000_8000, 1, 0, 0, 1, 0, 2, 2, 0, 0);
    tbl[5] = mk(16'hA55A, 1'b1, 32'hBEEF_CAFE, 32'h1234_5678,
                64'h0001_0010_0002_0020, 32'h0003_0030, 0, 0, 0, 0, 0, 0, 0, 0, 10);

    bus.train = 1'b0; bus.argument_valid = 1'b0; bus.argument_data = '0;
    bus.result_ready = 1'b0; bus.error_valid = 1'b0; bus.error_data = '0;
    bus.propagate_ready = 1'b0; bus.node_argument_ready = '0;
    bus.node_result_valid = '0; bus.node_result_data = '0;
    bus.node_error_ready = '0; bus.node_propagate_valid = '0;
    bus.node_propagate_data = '0;

    #1;
    chk_idle("reset");
    chk("reset_node_train", 64'(bus.node_train), 64'd0);
    chk("reset_result_data", 64'(bus.result_data), 64'd0);
    chk("reset_propagate_data", 64'(bus.propagate_data), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset while collecting, after node 0 has already handshaken
    bus.node_result_data    = 32'hAAAA_5555;
    bus.node_propagate_data = 64'h0000_0100_0000_0200;
    do_arg(16'h0102, 1'b1);
    node_phase(0, 0, 0);
    node_phase(1, 0, 0);
    do_result(32'hAAAA_5555, 0);
    do_error(32'h0000_0001);
    node_phase(2, 0, 0);
    @(negedge clock);
    chk("coll_ready", 64'(bus.node_propagate_ready), 64'd3);
    bus.node_propagate_valid = 2'b01;
    @(posedge clock);
    #1;
    bus.node_propagate_valid = 2'b00;
    chk("coll_partial", 64'(bus.node_propagate_ready), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("mid_reset");
    @(negedge clock);
    chk_idle("mid_reset_held");
    chk("mid_reset_propagate_data", 64'(bus.propagate_data), 64'd0);
    reset = 1'b0;
    run_vec(mk(16'h0908, 1'b1, 32'h0BAD_F00D, 32'h0000_FFFF,
               64'hFFFF_0003_0004_0002, 32'h0003_0005, 0, 1, 1, 0, 0, 1, 1, 0, 1));

    for (int i = 0; i < 20; i++) begin
      rp = {$urandom, $urandom};
      rv = mk(16'($urandom), 1'($urandom), $urandom, $urandom, rp, model_prop(rp),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      run_vec(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
